t03_data_mem_ctrl: RTL

- Memory-stage controller directly upstream of the writeback mux.
- Turns the core's load/store controls (ALU result as address) into a single-outstanding request/ack bus transaction, and stalls the core until the transaction completes.
- Returns a registered, lane-aligned memory_value, so writeback's byte path can use memory_value[7:0] directly.

---
 rtl/t03_mem_pkg.sv | 15 +
 rtl/t03_byte_lane.sv | 26 ++
 rtl/t03_data_mem_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/t03_mem_pkg.sv
// Shared types and constants for the t03 data-memory controller.
// Optional watchdog build macro: T03_DATA_MEM_TIMEOUT_EN.
package t03_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]  SEL_WORD          = 4'b1111;
    localparam logic [3:0]  SEL_BYTE0         = 4'b0001;
    localparam logic [31:0] TIMEOUT_ERR_VALUE = 32'hDEADBEEF;

endpackage

// File: rtl/t03_byte_lane.sv
// Byte-lane steering: store lane enables/replication and load byte extraction.
// Purely combinational; shared between issue and completion.
module t03_byte_lane
    import t03_mem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic        is_byte,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_val
);

    always_comb begin
        sel      = SEL_WORD;
        wdata    = store_data;
        load_val = rdata;
        if (is_byte) begin
            sel      = SEL_BYTE0 << addr;
            wdata    = {4{store_data[7:0]}};
            load_val = {24'b0, rdata[8*addr +: 8]};
        end
    end

endmodule

// File: rtl/t03_data_mem_ctrl.sv
// Memory-stage controller: one outstanding req/ack transaction, core stalled until done.
// Define T03_DATA_MEM_TIMEOUT_EN to add the BUSY watchdog and mem_error output.
module t03_data_mem_ctrl
    import t03_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              load_byte,
    input  logic              store_byte,
    input  logic [31:0]       address,
    input  logic [31:0]       store_data,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_sel,
    output logic [31:0]       memory_value,
`ifdef T03_DATA_MEM_TIMEOUT_EN
    output logic              mem_error,
`endif
    output logic              mem_stall
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state, state_nxt;
    logic        issue;
    logic        byte_q;
    logic [1:0]  lane_q;
    logic [1:0]  lane_addr;
    logic        lane_byte;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;
    logic        timeout;

    assign issue = (state == IDLE) && (mem_read || mem_write);

    // At issue the lane logic sees live inputs; afterwards it sees the latched lane for load extraction.
    assign lane_addr = (state == IDLE) ? address[1:0] : lane_q;
    assign lane_byte = (state == IDLE) ? (mem_write ? store_byte : load_byte) : byte_q;

    t03_byte_lane u_lane (
        .addr       (lane_addr),
        .is_byte    (lane_byte),
        .store_data (store_data),
        .rdata      (bus_rdata),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_val   (lane_load)
    );

`ifdef T03_DATA_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] busy_cnt;

    assign timeout = (state == BUSY) && !bus_ack && (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            busy_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            mem_error <= timeout;
            if (issue)
                busy_cnt <= '0;
            else if (state == BUSY)
                busy_cnt <= busy_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (mem_read || mem_write) state_nxt = BUSY;
            BUSY:    if (bus_ack || timeout)    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stall is gated by reset so nothing is driven high while nRst is low.
    always_comb begin
        bus_req   = 1'b0;
        mem_stall = 1'b0;
        if (nRst) begin
            bus_req   = (state == BUSY);
            mem_stall = (state == BUSY) || issue;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_sel      <= '0;
            byte_q       <= 1'b0;
            lane_q       <= '0;
            memory_value <= '0;
        end else begin
            if (issue) begin
                bus_we    <= mem_write;
                bus_addr  <= {address[ADDR_W-1:2], 2'b00};
                bus_wdata <= lane_wdata;
                bus_sel   <= lane_sel;
                byte_q    <= lane_byte;
                lane_q    <= address[1:0];
            end
            if (state == BUSY && bus_ack && !bus_we)
                memory_value <= lane_load;
            else if (timeout)
                memory_value <= TIMEOUT_ERR_VALUE;
        end
    end

endmodule
